// File: rtl/step_scheduler_pkg.sv
// rtl/step_scheduler_pkg.sv - shared state/direction codes, grid size and direction helper for the step scheduler
package step_scheduler_pkg;

  typedef enum logic [1:0] {
    GS_RUNNING = 2'b00,
    GS_DIE     = 2'b01,
    GS_INITIAL = 2'b10
  } game_state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_COMMIT
  } sched_state_t;

  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  localparam int TICK_W = 25;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/step_scheduler_if.sv
// rtl/step_scheduler_if.sv - scheduler <-> snake datapath bus: body reads, head/food inputs, step commit
interface step_scheduler_if;
  import step_scheduler_pkg::*;

  logic [5:0] snake_length;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [5:0] seg_idx;
  logic [4:0] seg_x;
  logic [4:0] seg_y;
  logic [4:0] food_x;
  logic [4:0] food_y;
  logic       step_valid;
  logic [4:0] next_x;
  logic [4:0] next_y;
  logic [1:0] step_dir;
  logic       get_food;

  modport master (
    input  snake_length, head_x, head_y, seg_x, seg_y, food_x, food_y,
    output seg_idx, step_valid, next_x, next_y, step_dir, get_food
  );

  modport slave (
    output snake_length, head_x, head_y, seg_x, seg_y, food_x, food_y,
    input  seg_idx, step_valid, next_x, next_y, step_dir, get_food
  );
endinterface

// File: rtl/step_scheduler_period_gen.sv
// rtl/step_scheduler_period_gen.sv - length/slow dependent step period and move tick counter
module step_scheduler_period_gen
  import step_scheduler_pkg::*;
#(
  parameter int BASE_PERIOD = 12_500_000,
  parameter int MIN_PERIOD  = 2_500_000,
  parameter int SPEED_STEP  = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] snake_length,
  input  logic       slow,
  input  logic       pause,
  input  logic       enable,
  input  logic       clear,
  output logic       tick
);

  logic [TICK_W-1:0] count;
  logic [TICK_W-1:0] period;
  logic [31:0]       reduction;
  logic [31:0]       base_period;
  logic              advance;

  // Compare before subtracting so long snakes clamp to the floor instead of wrapping.
  always_comb begin
    reduction = 32'(snake_length >> 2) * 32'(SPEED_STEP);
    if (32'(BASE_PERIOD) >= reduction + 32'(MIN_PERIOD))
      base_period = 32'(BASE_PERIOD) - reduction;
    else
      base_period = 32'(MIN_PERIOD);
    period = slow ? TICK_W'(base_period << 1) : TICK_W'(base_period);
  end

  assign advance = enable && !pause;
  // >= so a period that shrinks under a running count still ticks promptly.
  assign tick    = advance && (count >= period - TICK_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (advance)
      count <= tick ? '0 : count + TICK_W'(1);
  end

endmodule

// File: rtl/step_scheduler.sv
// rtl/step_scheduler.sv - snake move sequencer: tick, direction latch, next head, body scan, commit
// Optional WRAP_WALLS_EN: head wraps at the grid edge and hit_boundary stays 0.
module step_scheduler
  import step_scheduler_pkg::*;
#(
  parameter int BASE_PERIOD = 12_500_000,
  parameter int MIN_PERIOD  = 2_500_000,
  parameter int SPEED_STEP  = 500_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             game_state,
  input  logic                   pause,
  input  logic                   slow,
  input  logic [1:0]             next_direction,
  step_scheduler_if.master       sif,
  output logic                   hit_boundary,
  output logic                   hit_self,
  output logic                   busy
);

  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

  sched_state_t state, state_n;
  dir_t         dir_q, dir_pend, cand, new_dir;
  logic [4:0]   nx, ny, calc_x, calc_y;
  logic [5:0]   idx, last_q, calc_last;
  logic         grow_q, calc_grow, calc_empty, wall, boundary;
  logic         running, initial_st, tick;
  logic         set_bound, set_self, load_calc, seg_match;

  assign running    = (game_state == GS_RUNNING);
  assign initial_st = (game_state == GS_INITIAL);
  assign busy       = (state != ST_IDLE);
  assign seg_match  = (sif.seg_x == nx) && (sif.seg_y == ny);

  assign sif.next_x   = nx;
  assign sif.next_y   = ny;
  assign sif.step_dir = dir_q;

  step_scheduler_period_gen #(
    .BASE_PERIOD(BASE_PERIOD),
    .MIN_PERIOD (MIN_PERIOD),
    .SPEED_STEP (SPEED_STEP)
  ) u_period (
    .clk         (clk),
    .rst         (rst),
    .snake_length(sif.snake_length),
    .slow        (slow),
    .pause       (pause),
    .enable      (state == ST_IDLE && running),
    .clear       (initial_st),
    .tick        (tick)
  );

  // Next head; the edge cases pre-load the wrapped coordinate for the wrap build.
  always_comb begin
    cand    = dir_t'(next_direction);
    new_dir = (cand == opposite(dir_q)) ? dir_q : cand;
    calc_x  = sif.head_x;
    calc_y  = sif.head_y;
    wall    = 1'b0;
    case (new_dir)
      DIR_UP: begin
        if (sif.head_y == 5'd0) begin wall = 1'b1; calc_y = Y_MAX; end
        else calc_y = sif.head_y - 5'd1;
      end
      DIR_DOWN: begin
        if (sif.head_y == Y_MAX) begin wall = 1'b1; calc_y = 5'd0; end
        else calc_y = sif.head_y + 5'd1;
      end
      DIR_RIGHT: begin
        if (sif.head_x == X_MAX) begin wall = 1'b1; calc_x = 5'd0; end
        else calc_x = sif.head_x + 5'd1;
      end
      default: begin
        if (sif.head_x == 5'd0) begin wall = 1'b1; calc_x = X_MAX; end
        else calc_x = sif.head_x - 5'd1;
      end
    endcase
`ifdef WRAP_WALLS_EN
    boundary = 1'b0;
`else
    boundary = wall;
`endif
    calc_grow  = (calc_x == sif.food_x) && (calc_y == sif.food_y);
    // Without growth the tail cell is vacated this step, so it is not scanned.
    calc_last  = calc_grow ? sif.snake_length - 6'd1 : sif.snake_length - 6'd2;
    calc_empty = calc_grow ? (sif.snake_length < 6'd2) : (sif.snake_length < 6'd3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n        = state;
    sif.step_valid = 1'b0;
    sif.get_food   = 1'b0;
    sif.seg_idx    = '0;
    set_bound      = 1'b0;
    set_self       = 1'b0;
    load_calc      = 1'b0;
    if (state == ST_SCAN) sif.seg_idx = idx;
    if (!running) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (tick) state_n = ST_CALC;
        ST_CALC: begin
          load_calc = 1'b1;
          if (boundary) begin
            set_bound = 1'b1;
            state_n   = ST_IDLE;
          end else if (calc_empty) begin
            state_n = ST_COMMIT;
          end else begin
            state_n = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (seg_match) begin
            set_self = 1'b1;
            state_n  = ST_IDLE;
          end else if (idx == last_q) begin
            state_n = ST_COMMIT;
          end
        end
        default: begin
          sif.step_valid = 1'b1;
          sif.get_food   = grow_q;
          state_n        = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q        <= DIR_RIGHT;
      dir_pend     <= DIR_RIGHT;
      nx           <= '0;
      ny           <= '0;
      grow_q       <= 1'b0;
      last_q       <= '0;
      idx          <= '0;
      hit_boundary <= 1'b0;
      hit_self     <= 1'b0;
    end else begin
      if (load_calc) begin
        nx       <= calc_x;
        ny       <= calc_y;
        dir_pend <= new_dir;
        grow_q   <= calc_grow;
        last_q   <= calc_last;
        idx      <= 6'd1;
      end else if (state == ST_SCAN) begin
        idx <= idx + 6'd1;
      end
      if (initial_st) begin
        hit_boundary <= 1'b0;
        hit_self     <= 1'b0;
        dir_q        <= DIR_RIGHT;
      end else begin
        if (set_bound)      hit_boundary <= 1'b1;
        if (set_self)       hit_self     <= 1'b1;
        if (sif.step_valid) dir_q        <= dir_pend;
      end
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// tb/tb_step_scheduler.sv - directed bench with a step-level snake model for step_scheduler
module tb_step_scheduler;

  localparam int BP = 20;
  localparam int MP = 8;
  localparam int SS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] game_state;
  logic       pause, slow;
  logic [1:0] next_direction;
  logic       hit_boundary, hit_self, busy;
  logic [4:0] fx, fy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  step_scheduler_if sif();

  step_scheduler #(.BASE_PERIOD(BP), .MIN_PERIOD(MP), .SPEED_STEP(SS)) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .pause(pause), .slow(slow),
    .next_direction(next_direction), .sif(sif.master),
    .hit_boundary(hit_boundary), .hit_self(hit_self), .busy(busy)
  );

  // Snake body owned by the model process; directed code requests loads via ld_*.
  logic [4:0] bx [64];
  logic [4:0] by [64];
  int         len = 1;
  logic [4:0] ld_x [64];
  logic [4:0] ld_y [64];
  int         ld_len = 1;
  int         load_seq = 0;
  int         load_seen = 0;

  assign sif.snake_length = 6'(len);
  assign sif.head_x       = bx[0];
  assign sif.head_y       = by[0];
  assign sif.seg_x        = bx[sif.seg_idx];
  assign sif.seg_y        = by[sif.seg_idx];
  assign sif.food_x       = fx;
  assign sif.food_y       = fy;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step-level model state
  logic [1:0] mdir;
  logic       mhb, mhs, pend, prev_busy;
  logic       ecoll, egrow, ebnd;
  logic [1:0] edir;
  int         ex, ey, elast, efirst, enreads, exp_idx, reads;
  int         sv_count = 0, sv_cyc = 0, prev_sv_cyc = 0, last_reads = 0;
  logic       last_grow;

  always @(negedge clk) begin : model
    int cand;
    if (!rst) begin
      check("reset_step_valid", sif.step_valid, 0);
      check("reset_busy", busy, 0);
      mdir = 2'd2; mhb = 1'b0; mhs = 1'b0; pend = 1'b0;
    end else begin
      check("hit_boundary", hit_boundary, mhb);
      check("hit_self", hit_self, mhs);
      check("step_dir", sif.step_dir, mdir);
      if (game_state != 2'b00) begin
        check("no_step_when_stopped", sif.step_valid, 0);
        pend = 1'b0;
        if (game_state == 2'b10) begin mhb = 1'b0; mhs = 1'b0; mdir = 2'd2; end
      end else begin
        if (busy && !prev_busy) begin
          cand = int'(next_direction);
          if ((cand == 0 && mdir == 1) || (cand == 1 && mdir == 0) ||
              (cand == 2 && mdir == 3) || (cand == 3 && mdir == 2)) edir = mdir;
          else edir = 2'(cand);
          ex = int'(bx[0]); ey = int'(by[0]);
          case (edir)
            2'd0: ey = ey - 1;
            2'd1: ey = ey + 1;
            2'd2: ex = ex + 1;
            default: ex = ex - 1;
          endcase
          ebnd = (ex < 0) || (ex > 31) || (ey < 0) || (ey > 23);
`ifdef WRAP_WALLS_EN
          ex = (ex + 32) % 32; ey = (ey + 24) % 24; ebnd = 1'b0;
`endif
          egrow  = !ebnd && ex == int'(fx) && ey == int'(fy);
          elast  = egrow ? len - 1 : len - 2;
          enreads = (elast > 0) ? elast : 0;
          efirst = 0;
          if (!ebnd)
            for (int i = 1; i <= elast; i++)
              if (efirst == 0 && int'(bx[i]) == ex && int'(by[i]) == ey) efirst = i;
          ecoll = ebnd || (efirst != 0);
          pend = 1'b1; exp_idx = 1; reads = 0;
          if (ebnd) mhb = 1'b1;
        end
        if (sif.seg_idx != 0) begin
          check("seg_idx_order", sif.seg_idx, exp_idx);
          if (int'(sif.seg_idx) == efirst) mhs = 1'b1;
          exp_idx++; reads++;
        end
        if (sif.step_valid) begin
          check("step_expected", pend && !ecoll, 1);
          check("next_x", sif.next_x, ex);
          check("next_y", sif.next_y, ey);
          check("get_food", sif.get_food, egrow);
          check("scan_reads", reads, enreads);
          mdir = edir; pend = 1'b0;
          sv_count++; prev_sv_cyc = sv_cyc; sv_cyc = cyc;
          last_reads = reads; last_grow = sif.get_food;
        end else if (prev_busy && !busy && pend) begin
          check("abort_is_collision", ecoll, 1);
          pend = 1'b0;
        end
      end
    end
    prev_busy = rst ? busy : 1'b0;
    if (load_seq != load_seen) begin
      load_seen = load_seq;
      len = ld_len;
      for (int i = 0; i < 64; i++) begin bx[i] = ld_x[i]; by[i] = ld_y[i]; end
    end else if (rst && game_state == 2'b00 && sif.step_valid) begin
      for (int i = 63; i > 0; i--) begin bx[i] = bx[i-1]; by[i] = by[i-1]; end
      bx[0] = sif.next_x; by[0] = sif.next_y;
      if (sif.get_food) len++;
    end
  end

  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic load_line(input int l, input int hx, input int hy);
    for (int i = 0; i < 64; i++) begin ld_x[i] = 5'(hx - i); ld_y[i] = 5'(hy); end
    ld_len = l;
  endtask

  task automatic apply_load();
    load_seq++;
    tick_wait(2);
  endtask

  task automatic wait_step(input string name, input int max);
    int start, n;
    start = sv_count; n = 0;
    while (sv_count == start && n < max) begin @(posedge clk); #1; n++; end
    check({name, "_step_seen"}, sv_count > start, 1);
  endtask

  task automatic wait_seg(input string name, input int k, input int max);
    int n;
    n = 0;
    while (int'(sif.seg_idx) != k && n < max) begin @(posedge clk); #1; n++; end
    check({name, "_seg_reached"}, sif.seg_idx, k);
  endtask

  initial begin
    int base, n;
    rst = 1'b0; game_state = 2'b10; pause = 1'b0; slow = 1'b0;
    next_direction = 2'd2; fx = 5'd0; fy = 5'd20;
    load_line(3, 10, 5);
    load_seq = 1;
    tick_wait(3);
    check("rst_step_dir_right", sif.step_dir, 2);
    check("rst_hits", {hit_boundary, hit_self}, 0);
    check("rst_seg_idx", sif.seg_idx, 0);
    check("rst_next_xy", {sif.next_x, sif.next_y}, 0);
    rst = 1'b1;
    tick_wait(2);

    // Length 3 moving right: period 20, one scanned segment.
    game_state = 2'b00;
    wait_step("len3_a", 60);
    wait_step("len3_b", 60);
    check("len3_interval", sv_cyc - prev_sv_cyc, 23);
    check("len3_next_x", sif.next_x, 12);

    slow = 1'b1;
    wait_step("slow", 100);
    check("slow_interval", sv_cyc - prev_sv_cyc, 43);
    slow = 1'b0;
    wait_step("unslow", 60);
    check("unslow_interval", sv_cyc - prev_sv_cyc, 23);

    // Reversal ignored, then a legal turn.
    next_direction = 2'd3;
    wait_step("reverse", 60);
    check("reverse_keeps_right", sif.step_dir, 2);
    check("reverse_next_x", sif.next_x, 15);
    next_direction = 2'd0;
    wait_step("turn_up", 60);
    check("turn_up_dir", sif.step_dir, 0);
    check("turn_up_next_y", sif.next_y, 4);

    // Right wall.
    game_state = 2'b10; next_direction = 2'd2;
    load_line(3, 31, 5); apply_load();
    base = sv_count;
    game_state = 2'b00;
`ifdef WRAP_WALLS_EN
    wait_step("wrap", 60);
    check("wrap_next_x", sif.next_x, 0);
    check("wrap_next_y", sif.next_y, 5);
`else
    n = 0;
    while (!hit_boundary && n < 60) begin tick_wait(1); n++; end
    check("wall_hit_boundary", hit_boundary, 1);
    check("wall_no_step", sv_count, base);
`endif
    game_state = 2'b01;
    tick_wait(2);

    // Food directly ahead, length 4.
    game_state = 2'b10;
    load_line(4, 10, 5); fx = 5'd11; fy = 5'd5; apply_load();
    game_state = 2'b00;
    wait_step("food", 60);
    check("food_get_food", last_grow, 1);
    check("food_scan_count", last_reads, 3);
    check("food_len_grew", len, 5);
    game_state = 2'b10; fx = 5'd0; fy = 5'd20;
    tick_wait(2);

    // Segment 2 sits on the next head.
    load_line(4, 10, 5); ld_x[2] = 5'd11; ld_x[3] = 5'd12; apply_load();
    base = sv_count;
    game_state = 2'b00;
    n = 0;
    while (!hit_self && n < 60) begin tick_wait(1); n++; end
    check("self_hit", hit_self, 1);
    check("self_no_step", sv_count, base);
    game_state = 2'b01;
    tick_wait(2);

    // Only the tail is on the next head: it moves away, so the step is legal.
    load_line(4, 10, 5); ld_y[2] = 5'd6; ld_x[3] = 5'd11; ld_y[3] = 5'd5; apply_load();
    game_state = 2'b00;
    wait_step("tail", 60);
    check("tail_next_x", sif.next_x, 11);
    check("tail_scan_count", last_reads, 2);
    check("tail_hit_self_sticky", hit_self, 1);

    // Pause holds the tick.
    pause = 1'b1;
    base = sv_count;
    tick_wait(100);
    check("pause_no_step", sv_count, base);
    pause = 1'b0;
    wait_step("unpause", 60);

    // INITIAL in the middle of a scan.
    game_state = 2'b01;
    load_line(8, 10, 10); apply_load();
    base = sv_count;
    game_state = 2'b00;
    wait_seg("init_mid", 3, 60);
    game_state = 2'b10;
    tick_wait(2);
    check("init_mid_idle", busy, 0);
    check("init_mid_no_step", sv_count, base);
    check("init_mid_flags_clear", {hit_boundary, hit_self}, 0);

    // Reset in the middle of a scan.
    game_state = 2'b00;
    wait_seg("rst_mid", 2, 60);
    rst = 1'b0;
    #1;
    check("rst_mid_idle", busy, 0);
    check("rst_mid_seg_idx", sif.seg_idx, 0);
    tick_wait(2);
    rst = 1'b1;
    check("rst_mid_no_step", sv_count, base);
    wait_step("after_rst", 60);
    check("after_rst_next_x", sif.next_x, 11);

    tick_wait(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
